// File: rtl/scroll_pkg.sv
// ---------------------------------------------------------------------------
// scroll_pkg
// Shared definitions for the message scroller: character width, the 4-bit
// character codes understood by the LED digit decoder, and the power-up
// message loaded into the scroller's register file on reset.
// ---------------------------------------------------------------------------
package scroll_pkg;

  localparam int CHAR_W      = 4;
  localparam int DEFAULT_LEN = 16;

  // Character codes as decoded by the downstream seven-segment driver.
  // Codes 0..14 are hex glyphs 0..E; code 15 lights no segments.
  typedef enum logic [CHAR_W-1:0] {
    CH_0     = 4'h0,
    CH_1     = 4'h1,
    CH_2     = 4'h2,
    CH_3     = 4'h3,
    CH_4     = 4'h4,
    CH_5     = 4'h5,
    CH_6     = 4'h6,
    CH_7     = 4'h7,
    CH_8     = 4'h8,
    CH_9     = 4'h9,
    CH_A     = 4'hA,
    CH_B     = 4'hB,
    CH_C     = 4'hC,
    CH_D     = 4'hD,
    CH_E     = 4'hE,
    CH_BLANK = 4'hF
  } char_code_e;

  // Power-up message: every code once, in ascending order.
  localparam logic [CHAR_W-1:0] DEFAULT_MSG [DEFAULT_LEN] = '{
    CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7,
    CH_8, CH_9, CH_A, CH_B, CH_C, CH_D, CH_E, CH_BLANK
  };

endpackage

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Synchronizes a bouncing push-button into the clk domain, accepts a level
// change only after DEBOUNCE_CYCLES consecutive stable samples, and emits a
// single-cycle pulse when the accepted level goes from released to pressed.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   btn_raw   raw button input, asynchronous to clk
//   btn_pulse one-cycle pulse on each accepted press (release gives none)
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_meta;
  logic          btn_sync;
  logic          stable;
  logic [CW-1:0] count;
  logic          differ;
  logic          accept;

  assign differ = (btn_sync != stable);
  assign accept = differ && (count == CNT_MAX);

  // Two-flop synchronizer; nothing downstream sees btn_raw directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // Any sample that agrees with the accepted level restarts the count, so
  // bounces shorter than DEBOUNCE_CYCLES never flip the stable level.
  // The pulse is raised in the same edge that flips stable 0->1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable    <= 1'b0;
      count     <= '0;
      btn_pulse <= 1'b0;
    end else begin
      btn_pulse <= accept && !stable;
      if (accept) begin
        stable <= ~stable;
        count  <= '0;
      end else if (differ) begin
        count  <= count + CW'(1);
      end else begin
        count  <= '0;
      end
    end
  end

endmodule

// File: rtl/message_scroller.sv
// ---------------------------------------------------------------------------
// message_scroller
// Holds a MSG_LEN-entry message of character codes and presents a 4-wide
// sliding window of it to the LED driver. The window advances on a debounced
// button press or on an auto-scroll timer; entries are writable at run time.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   btn_step          raw step button (bouncy, asynchronous)
//   auto_en           auto-scroll enable switch (asynchronous)
//   wr_en/addr/data   single-cycle message write port
//   char3..char0      registered window, char3 = msg[pos] (leftmost)
//   pos               current window start index
// ---------------------------------------------------------------------------
module message_scroller
  import scroll_pkg::*;
#(
  parameter int MSG_LEN         = 16,
  parameter int SCROLL_TICKS    = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  localparam int AW             = $clog2(MSG_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_step,
  input  logic              auto_en,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  output logic [CHAR_W-1:0] char3,
  output logic [CHAR_W-1:0] char2,
  output logic [CHAR_W-1:0] char1,
  output logic [CHAR_W-1:0] char0,
  output logic [AW-1:0]     pos
);

  localparam int TW = (SCROLL_TICKS > 2) ? $clog2(SCROLL_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(SCROLL_TICKS - 1);

  logic              btn_pulse;
  logic              auto_meta;
  logic              auto_sync;
  logic [TW-1:0]     timer;
  logic              tick_pulse;
  logic              step;
  logic [CHAR_W-1:0] msg [MSG_LEN];

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_step),
    .btn_pulse(btn_pulse)
  );

  // A coincident button press and timer wrap still give a single advance.
  assign tick_pulse = auto_sync && (timer == TICK_MAX);
  assign step       = btn_pulse || tick_pulse;

  // auto_en is a free-running switch, so it gets its own synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_meta <= 1'b0;
      auto_sync <= 1'b0;
    end else begin
      auto_meta <= auto_en;
      auto_sync <= auto_meta;
    end
  end

  // Holding the timer at zero while disabled discards any partial period,
  // so re-enabling always waits a full SCROLL_TICKS before the first step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!auto_sync || (timer == TICK_MAX)) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // MSG_LEN is a power of two, so natural overflow gives the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= '0;
    end else if (step) begin
      pos <= pos + AW'(1);
    end
  end

  // Message register file; reset reloads the default message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg[i] <= DEFAULT_MSG[i % DEFAULT_LEN];
      end
    end else if (wr_en) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // Window outputs are re-read every cycle, so writes and steps both show up
  // one edge after the register they touch has changed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char3 <= DEFAULT_MSG[0];
      char2 <= DEFAULT_MSG[1 % DEFAULT_LEN];
      char1 <= DEFAULT_MSG[2 % DEFAULT_LEN];
      char0 <= DEFAULT_MSG[3 % DEFAULT_LEN];
    end else begin
      char3 <= msg[pos];
      char2 <= msg[pos + AW'(1)];
      char1 <= msg[pos + AW'(2)];
      char0 <= msg[pos + AW'(3)];
    end
  end

endmodule

// File: tb/tb_message_scroller.sv
// ---------------------------------------------------------------------------
// tb_message_scroller
// Directed self-checking bench for message_scroller with short timing
// parameters. A reference model of pos and the message produces expected
// windows that are queued when stimulus is applied and popped when the DUT
// output is sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_message_scroller;
  import scroll_pkg::*;

  localparam int MSG_LEN         = 16;
  localparam int SCROLL_TICKS    = 8;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int AW              = $clog2(MSG_LEN);

  logic              clk = 1'b0;
  logic              reset;
  logic              btn_step;
  logic              auto_en;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [CHAR_W-1:0] wr_data;
  logic [CHAR_W-1:0] char3, char2, char1, char0;
  logic [AW-1:0]     pos;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [23:0]       exp_q [$];
  logic [CHAR_W-1:0] msg_model [MSG_LEN];
  logic [AW-1:0]     pos_model;

  message_scroller #(
    .MSG_LEN        (MSG_LEN),
    .SCROLL_TICKS   (SCROLL_TICKS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_step(btn_step),
    .auto_en (auto_en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .char3   (char3),
    .char2   (char2),
    .char1   (char1),
    .char0   (char0),
    .pos     (pos)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure auto-scroll spacing.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] window_of(input logic [AW-1:0] p);
    logic [AW-1:0] p1, p2, p3;
    p1 = p + AW'(1);
    p2 = p + AW'(2);
    p3 = p + AW'(3);
    return {p, msg_model[p], msg_model[p1], msg_model[p2], msg_model[p3]};
  endfunction

  task automatic step_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_model();
    for (int i = 0; i < MSG_LEN; i++) msg_model[i] = CHAR_W'(i);
    pos_model = '0;
  endtask

  task automatic expect_window();
    exp_q.push_back(window_of(pos_model));
  endtask

  task automatic check_output(input string tag);
    logic [23:0] observed;
    logic [23:0] expected;
    expected = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    observed = {pos, char3, char2, char1, char0};
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed {pos,c3,c2,c1,c0}=%h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Bounded wait for pos to reach a value; a timeout shows up as a failed
  // comparison of pos against the target.
  task automatic wait_pos(input logic [AW-1:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (pos !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, 32'(pos), 32'(target));
  endtask

  initial begin
    int last_cyc;
    int now_cyc;

    reset    = 1'b1;
    btn_step = 1'b0;
    auto_en  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    reset_model();

    // Reset state
    step_cycles(3);
    expect_window();
    check_output("reset_window");
    reset = 1'b0;
    step_cycles(2);
    expect_window();
    check_output("idle_after_reset");

    // Clean press held 10 cycles: one advance within 2+4+3 cycles
    btn_step  = 1'b1;
    pos_model = pos_model + AW'(1);
    expect_window();
    wait_pos(pos_model, 8, "btn_press_pos");
    step_cycles(1);
    check_output("btn_press_window");
    step_cycles(2);
    btn_step = 1'b0;
    step_cycles(12);
    expect_window();
    check_output("btn_single_advance");

    // Bouncing button never stable long enough
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      step_cycles(2);
    end
    btn_step = 1'b0;
    step_cycles(12);
    expect_window();
    check_output("bounce_rejected");

    // Auto-scroll: 17 advances exactly SCROLL_TICKS apart, wrapping 15 -> 0
    auto_en  = 1'b1;
    last_cyc = 0;
    for (int k = 1; k <= 17; k++) begin
      pos_model = pos_model + AW'(1);
      wait_pos(pos_model, SCROLL_TICKS + 4, $sformatf("auto_step_%0d", k));
      now_cyc = cyc;
      if (k > 1) check_value($sformatf("auto_gap_%0d", k), 32'(now_cyc - last_cyc), SCROLL_TICKS);
      last_cyc = now_cyc;
      if (pos_model == '0) begin
        step_cycles(1);
        expect_window();
        check_output("auto_wrap_window");
      end
    end
    auto_en = 1'b0;
    step_cycles(20);
    expect_window();
    check_output("auto_disabled_hold");

    // Reach pos 14, then write msg[0] in the same cycle as the next tick
    auto_en   = 1'b1;
    pos_model = AW'(14);
    wait_pos(pos_model, 12 * SCROLL_TICKS + 16, "auto_reach_14");
    step_cycles(1);
    expect_window();
    check_output("window_at_14");
    step_cycles(SCROLL_TICKS - 2);
    wr_en        = 1'b1;
    wr_addr      = '0;
    wr_data      = 4'd9;
    msg_model[0] = 4'd9;
    step_cycles(1);
    wr_en     = 1'b0;
    auto_en   = 1'b0;
    pos_model = AW'(15);
    check_value("tick_with_write_pos", 32'(pos), 32'(pos_model));
    expect_window();
    step_cycles(1);
    check_output("tick_with_write_window");

    // Reset between a button edge and debounce completion
    step_cycles(5);
    btn_step = 1'b1;
    step_cycles(3);
    reset = 1'b1;
    reset_model();
    step_cycles(1);
    expect_window();
    check_output("reset_mid_debounce");
    btn_step = 1'b0;
    step_cycles(2);
    reset = 1'b0;
    step_cycles(12);
    expect_window();
    check_output("no_step_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/message_scroller.md
# message_scroller

Character source directly upstream of the four-digit LED driver. It holds a 16-entry message of 4-bit character codes and presents a 4-character sliding window on char3..char0, which feed the driver's per-digit character inputs. The window advances on a debounced push-button or on an internal auto-scroll timer. Message contents can be rewritten at run time through a single-cycle write port.

## Interface
- MSG_LEN, 16, message length in characters; power of two, ≥ 4
- SCROLL_TICKS, 25_000_000, clk cycles per auto-scroll step; ≥ 2
- DEBOUNCE_CYCLES, 500_000, consecutive stable synchronized cycles required to accept a button level change; ≥ 2
- clk  in  1  system clock; one clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- btn_step  in  1  raw push-button, asynchronous to clk, bounces
- auto_en  in  1  1 = auto-scroll timer enabled; quasi-static switch
- wr_en  in  1  write strobe, one write per cycle
- wr_addr  in  log2(MSG_LEN)  message entry to write
- wr_data  in  4  character code to write
- char3  out  4  leftmost digit code = msg[pos]
- char2  out  4  msg[(pos+1) mod MSG_LEN]
- char1  out  4  msg[(pos+2) mod MSG_LEN]
- char0  out  4  rightmost digit code = msg[(pos+3) mod MSG_LEN]
- pos  out  log2(MSG_LEN)  current window start index

## Operation
- Reset (async assert, sync-safe release): msg ← DEFAULT_MSG; pos = 0; timer = 0; debouncer stable level = 0, counter = 0; both sync FFs = 0; char3..char0 = DEFAULT_MSG[0..3].
- btn_step and auto_en each pass through a 2-FF synchronizer before any use.
- Debouncer: the counter increments while the synchronized btn differs from the stable level; it clears when they match. When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, the stable level flips and the counter clears. A 0→1 change of the stable level raises btn_pulse for exactly one cycle. A 1→0 change produces no pulse.
- Timer: when synced auto_en = 0, timer is held at 0. When it is 1, timer counts 0..SCROLL_TICKS-1 and wraps. tick_pulse = 1 in the wrap cycle.
- step = btn_pulse OR tick_pulse. Coincident pulses give one advance, never two.
- On step: pos ← (pos+1) mod MSG_LEN. Wrap from MSG_LEN-1 to 0 is seamless. Window indices always wrap modulo MSG_LEN.
- On wr_en: msg[wr_addr] ← wr_data. A write and a step in the same cycle both take effect.
- char outputs are registered and recomputed every cycle from the current pos and msg registers.
- auto_en 1→0 mid-count: timer clears; no pending tick survives. The button works in both modes.

## Timing
- btn_step edge to btn_pulse: 2 sync cycles + DEBOUNCE_CYCLES cycles, ±1 cycle.
- Step pulse at cycle t: pos updates at edge t+1; char3..char0 reflect the new pos at edge t+2.
- Write at cycle t: msg updates at edge t+1; affected char output updates at edge t+2.
- Auto mode: period between consecutive pos increments is exactly SCROLL_TICKS cycles. First increment occurs SCROLL_TICKS cycles after synced auto_en rises.
- Reset asserted mid-operation: all state returns to reset values immediately; no step is pending after release.

## Structure
- Package scroll_pkg holds:
  - CHAR_W = 4
  - named character codes matching the LED decoder's 4-bit encoding, including BLANK
  - DEFAULT_MSG (MSG_LEN-entry constant array)
- Sub-module button_debouncer (params DEBOUNCE_CYCLES; ports clk, reset, btn_raw, btn_pulse) contains the synchronizer, debounce counter and rising-edge detector.
- Top level contains the auto_en synchronizer, timer, pos register, message register file and output registers.

## Test plan
Bench parameters: SCROLL_TICKS = 8, DEBOUNCE_CYCLES = 4.
- Reset, DEFAULT_MSG = 0..15 -> pos = 0, char3..char0 = 0,1,2,3.
- Clean btn_step 0→1 held 10 cycles -> exactly one increment; pos = 1, chars = 1,2,3,4, at most 2+4+3 cycles after the press.
- btn_step toggling every 2 cycles for 20 cycles, then stable 0 -> pos unchanged.
- auto_en = 1 for 8×17 cycles -> 17 increments spaced 8 cycles apart; pos wraps 15→0, chars after the wrap = 0,1,2,3.
- pos = 14 -> chars = 14,15,0,1. Write msg[0] = 9 at the same cycle as a timer tick -> pos = 15, chars = 15,9,1,2.
- Reset asserted between a button edge and its debounce completion -> no increment after release; pos = 0.
